fetch_stage: RTL and testbench

Instruction fetch and alignment stage of the small RV32 core. It issues word-aligned reads to instruction memory and buffers the returned words as 16-bit halfwords. From that buffer it extracts one 16-bit (compressed) or 32-bit instruction per cycle into a registered fetch/decode boundary. It handles redirects (branch, jump, trap, mret) coming back from the execute/CSR path and holds its output while the downstream stages stall.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory request bus, the redirect/stall controls and the
// fetch/decode boundary register outputs of the fetch stage.
interface fetch_stage_if;
   logic        imem_valid;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;

   modport master (
      output imem_valid, imem_addr, instr_valid, instr, pc,
      input  imem_ready, imem_rdata, redirect, redirect_pc, stall
   );

   modport slave (
      input  imem_valid, imem_addr, instr_valid, instr, pc,
      output imem_ready, imem_rdata, redirect, redirect_pc, stall
   );
endinterface

// File: rtl/fetch_stage.sv
// RV32 fetch/align stage: word reads from imem into a 4-halfword FIFO, one 16- or
// 32-bit instruction per cycle into a registered decode boundary.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);
   logic        pending_reg, pending_next;
   logic [31:0] req_addr_reg, req_addr_next;
   logic [31:0] fetch_addr_reg, fetch_addr_next;
   logic        skip_reg, skip_next;
   logic        drop_reg, drop_next;
   logic [2:0]  count_reg, count_next;
   logic [31:0] head_pc_reg, head_pc_next;
   logic [15:0] hw_reg [4];
   logic [3:0][15:0] hw_next;
   logic        instr_valid_reg;
   logic [31:0] instr_reg, pc_reg;

   logic        is_wide, have_instr, do_pop, complete, hold, do_push;
   logic [2:0]  pop_n, push_n, base;
   logic [3:0]  fill;
   logic [15:0] first_hw;

   assign is_wide    = (hw_reg[0][1:0] == 2'b11);
   assign have_instr = is_wide ? (count_reg >= 3'd2) : (count_reg >= 3'd1);
   assign do_pop     = !bus.redirect && !bus.stall && have_instr;
   assign pop_n      = !do_pop ? 3'd0 : (is_wide ? 3'd2 : 3'd1);
   assign complete   = pending_reg && bus.imem_ready;
   assign hold       = pending_reg && !bus.imem_ready;
   assign do_push    = complete && !drop_reg && !bus.redirect;
   assign push_n     = !do_push ? 3'd0 : (skip_reg ? 3'd1 : 3'd2);
   assign first_hw   = skip_reg ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0];
   assign base       = count_reg - pop_n;
   assign fill       = {1'b0, base} + {1'b0, push_n};

   // Entry gi keeps a surviving halfword shifted down by the pop, or takes new data.
   for (genvar gi = 0; gi < 4; gi++) begin : g_buf
      logic [1:0] src;
      assign src = 2'(gi) + pop_n[1:0];
      assign hw_next[gi] = (3'(gi) < base) ? hw_reg[src] :
                           (push_n != 3'd0 && 3'(gi) == base) ? first_hw :
                           (push_n == 3'd2 && 3'(gi) == base + 3'd1) ? bus.imem_rdata[31:16] :
                           hw_reg[gi];
   end

   always_comb begin
      count_next      = fill[2:0];
      fetch_addr_next = fetch_addr_reg;
      skip_next       = skip_reg;
      drop_next       = drop_reg;
      head_pc_next    = head_pc_reg;
      if (bus.redirect) begin
         count_next      = 3'd0;
         fetch_addr_next = {bus.redirect_pc[31:2], 2'b00};
         skip_next       = bus.redirect_pc[1];
         drop_next       = hold;
         head_pc_next    = bus.redirect_pc;
      end else begin
         if (complete) begin
            drop_next = 1'b0;
            if (!drop_reg)
               fetch_addr_next = fetch_addr_reg + 32'd4;
         end
         if (do_push && skip_reg)
            skip_next = 1'b0;
         if (do_pop)
            head_pc_next = head_pc_reg + (is_wide ? 32'd4 : 32'd2);
      end
      // A held request keeps its address even across a redirect; its data gets dropped.
      if (bus.redirect || hold)
         pending_next = 1'b1;
      else
         pending_next = (count_next <= 3'd2);
      req_addr_next = hold ? req_addr_reg : fetch_addr_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_reg     <= 1'b0;
         req_addr_reg    <= {RESET_PC[31:2], 2'b00};
         fetch_addr_reg  <= {RESET_PC[31:2], 2'b00};
         skip_reg        <= RESET_PC[1];
         drop_reg        <= 1'b0;
         count_reg       <= 3'd0;
         head_pc_reg     <= RESET_PC;
         instr_valid_reg <= 1'b0;
         instr_reg       <= 32'd0;
         pc_reg          <= 32'd0;
         for (int i = 0; i < 4; i++)
            hw_reg[i] <= 16'd0;
      end else begin
         pending_reg    <= pending_next;
         req_addr_reg   <= req_addr_next;
         fetch_addr_reg <= fetch_addr_next;
         skip_reg       <= skip_next;
         drop_reg       <= drop_next;
         count_reg      <= count_next;
         head_pc_reg    <= head_pc_next;
         for (int i = 0; i < 4; i++)
            hw_reg[i] <= hw_next[i];
         if (bus.redirect) begin
            instr_valid_reg <= 1'b0;
         end else if (!bus.stall) begin
            instr_valid_reg <= have_instr;
            if (have_instr) begin
               instr_reg <= is_wide ? {hw_reg[1], hw_reg[0]} : {16'd0, hw_reg[0]};
               pc_reg    <= head_pc_reg;
            end
         end
      end
   end

   // Issuing only at count<=2 means a returned word can never overflow the buffer.
   assert property (@(posedge clk) disable iff (!rst) fill <= 4'd4);

   assign bus.imem_valid  = pending_reg;
   assign bus.imem_addr   = req_addr_reg;
   assign bus.instr_valid = instr_valid_reg;
   assign bus.instr       = instr_reg;
   assign bus.pc          = pc_reg;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory responder, a
// boundary monitor, and a linear sequence of checked scenarios.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst;
   fetch_stage_if ifc();

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int lat   = 0;
   int wcnt  = 0;
   int cyc   = 0;
   logic [31:0] resp_addr = 32'd0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] obs_pc [$];
   logic [31:0] obs_in [$];
   int          obs_cyc [$];
   logic [31:0] req_q [$];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0000_0013;
   endfunction

   function automatic logic [31:0] seq_word(input logic [31:0] a);
      return {a[11:0], 20'h00093};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      obs_pc.delete(); obs_in.delete(); obs_cyc.delete(); req_q.delete();
   endtask

   task automatic do_reset(input int l);
      @(negedge clk);
      rst = 1'b0; ifc.redirect = 1'b0; ifc.stall = 1'b0; lat = l;
      tick(2);
      rst = 1'b1;
      clear_logs();
   endtask

   // Memory: ready after 'lat' waiting cycles of a request, one-cycle strobe.
   always @(negedge clk) begin
      if (ifc.imem_ready) wcnt = 0;
      if (rst && ifc.imem_valid) begin
         if (wcnt >= lat) begin
            ifc.imem_ready = 1'b1;
            ifc.imem_rdata = mem_rd(ifc.imem_addr);
            resp_addr      = ifc.imem_addr;
         end else begin
            ifc.imem_ready = 1'b0;
            wcnt++;
         end
      end else begin
         ifc.imem_ready = 1'b0;
         ifc.imem_rdata = 32'd0;
         wcnt = 0;
      end
   end

   logic        mon_st, mon_rd, mon_rs, mon_cp;
   logic [31:0] mon_a;
   always @(posedge clk) begin
      mon_st = ifc.stall; mon_rd = ifc.redirect; mon_rs = rst;
      mon_cp = ifc.imem_ready; mon_a = resp_addr;
      #1;
      cyc++;
      if (mon_rs && mon_cp && !mon_rd) req_q.push_back(mon_a);
      if (mon_rs && !mon_st && ifc.instr_valid) begin
         obs_pc.push_back(ifc.pc);
         obs_in.push_back(ifc.instr);
         obs_cyc.push_back(cyc);
         $display("instr pc=%h instr=%h cycle=%0d", ifc.pc, ifc.instr, cyc);
      end
   end

   logic [31:0] held_pc, held_in;
   logic        found;

   initial begin
      rst = 1'b0; ifc.redirect = 1'b0; ifc.redirect_pc = 32'd0; ifc.stall = 1'b0;
      // Reset state and first request after release; then straight 32-bit stream.
      mem[32'h0] = 32'h0000_0013; mem[32'h4] = 32'h0010_0093; mem[32'h8] = 32'h0020_0113;
      tick(3);
      check("rst_imem_valid", {31'd0, ifc.imem_valid}, 32'd0);
      check("rst_instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
      check("rst_instr", ifc.instr, 32'd0);
      check("rst_pc", ifc.pc, 32'd0);
      rst = 1'b1;
      clear_logs();
      tick(1);
      check("rel_imem_valid", {31'd0, ifc.imem_valid}, 32'd1);
      check("rel_imem_addr", ifc.imem_addr, 32'd0);
      tick(8);
      check("s1_pc0", obs_pc[0], 32'h0);  check("s1_in0", obs_in[0], 32'h0000_0013);
      check("s1_pc1", obs_pc[1], 32'h4);  check("s1_in1", obs_in[1], 32'h0010_0093);
      check("s1_pc2", obs_pc[2], 32'h8);  check("s1_in2", obs_in[2], 32'h0020_0113);
      check("s1_gap01", obs_cyc[1] - obs_cyc[0], 32'd1);
      check("s1_gap12", obs_cyc[2] - obs_cyc[1], 32'd1);

      // Two compressed instructions in one word.
      mem.delete(); mem[32'h0] = 32'h0505_4501;
      do_reset(0); tick(10);
      check("c2_pc0", obs_pc[0], 32'h0);  check("c2_in0", obs_in[0], 32'h0000_4501);
      check("c2_pc1", obs_pc[1], 32'h2);  check("c2_in1", obs_in[1], 32'h0000_0505);
      check("c2_pc2", obs_pc[2], 32'h4);  check("c2_in2", obs_in[2], 32'h0000_0013);

      // 32-bit instruction straddling a word boundary.
      mem.delete(); mem[32'h0] = 32'h0013_4501; mem[32'h4] = 32'h1234_0000;
      do_reset(0); tick(10);
      check("st_pc0", obs_pc[0], 32'h0);  check("st_in0", obs_in[0], 32'h0000_4501);
      check("st_pc1", obs_pc[1], 32'h2);  check("st_in1", obs_in[1], 32'h0000_0013);
      check("st_pc2", obs_pc[2], 32'h6);  check("st_in2", obs_in[2], 32'h0000_1234);

      // Redirect to an odd-halfword target.
      mem.delete(); mem[32'h100] = 32'h0013_4501; mem[32'h104] = 32'hABCD_0000;
      do_reset(0); tick(4);
      ifc.redirect = 1'b1; ifc.redirect_pc = 32'h102; clear_logs();
      tick(1);
      ifc.redirect = 1'b0;
      check("rd_instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
      check("rd_imem_valid", {31'd0, ifc.imem_valid}, 32'd1);
      check("rd_imem_addr", ifc.imem_addr, 32'h100);
      tick(8);
      check("rd_req0", req_q[0], 32'h100);
      check("rd_pc0", obs_pc[0], 32'h102); check("rd_in0", obs_in[0], 32'h0000_0013);
      check("rd_pc1", obs_pc[1], 32'h106); check("rd_in1", obs_in[1], 32'h0000_ABCD);

      // Redirect while a slow request to 0x8 is outstanding.
      mem.delete(); mem[32'h200] = 32'h0050_0293;
      do_reset(3);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         tick(1);
         if (ifc.imem_valid && ifc.imem_addr == 32'h8) found = 1'b1;
      end
      check("dp_req8_seen", {31'd0, found}, 32'd1);
      ifc.redirect = 1'b1; ifc.redirect_pc = 32'h200; clear_logs();
      tick(1);
      ifc.redirect = 1'b0;
      check("dp_instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
      check("dp_held_valid", {31'd0, ifc.imem_valid}, 32'd1);
      check("dp_held_addr", ifc.imem_addr, 32'h8);
      tick(20);
      check("dp_req0", req_q[0], 32'h8);
      check("dp_req1", req_q[1], 32'h200);
      check("dp_pc0", obs_pc[0], 32'h200); check("dp_in0", obs_in[0], 32'h0050_0293);

      // Six-cycle stall over a stream of distinct 32-bit instructions.
      mem.delete();
      for (int a = 0; a < 32'h100; a += 4) mem[a] = seq_word(a);
      do_reset(0); tick(6);
      held_pc = ifc.pc; held_in = ifc.instr;
      ifc.stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("sl_pc_hold", ifc.pc, held_pc);
         check("sl_in_hold", ifc.instr, held_in);
      end
      check("sl_imem_idle", {31'd0, ifc.imem_valid}, 32'd0);
      ifc.stall = 1'b0;
      tick(10);
      check("sl_enough", {31'd0, obs_pc.size() >= 10}, 32'd1);
      check("sl_first_pc", obs_pc[0], 32'h0);
      for (int i = 1; i < obs_pc.size(); i++) begin
         check("sl_seq_pc", obs_pc[i], obs_pc[i-1] + 32'd4);
         check("sl_seq_in", obs_in[i], seq_word(obs_pc[i]));
      end

      // Redirect raised together with stall still flushes.
      ifc.stall = 1'b1; ifc.redirect = 1'b1; ifc.redirect_pc = 32'h10; clear_logs();
      tick(1);
      ifc.redirect = 1'b0;
      check("rs_instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
      ifc.stall = 1'b0;
      tick(6);
      check("rs_pc0", obs_pc[0], 32'h10);
      check("rs_in0", obs_in[0], 32'h0100_0093);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
